dsp_sample_ctrl: RTL and testbench

DSP_SAMPLE_CTRL -- requirements
Module: dsp_sample_ctrl

---
 rtl/dsp_sample_pkg.sv | 13 +
 rtl/sample_fifo.sv | 71 +++++++
 rtl/dsp_sample_ctrl.sv | 146 ++++++++++++++
 tb/tb_dsp_sample_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_sample_pkg.sv
// Shared types and widths for the DSP sample controller.
package dsp_sample_pkg;

  localparam int SAMPLE_W = 16;
  localparam int CNT_W    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    RUN   = 2'd2
  } state_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO with registered output and occupancy.
// A pop on an empty FIFO together with a push forwards the pushed word
// straight to dout; a push on a full FIFO together with a pop is accepted.
module sample_fifo
  import dsp_sample_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = SAMPLE_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   pop_ok
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          wr_en;
  logic          rd_en;
  logic          bypass;

  // Decode accepted push/pop from occupancy.
  always_comb begin
    full   = (level == LW'(DEPTH));
    empty  = (level == '0);
    rd_en  = pop && !empty;
    bypass = pop && push && empty;
    wr_en  = push && !bypass && (!full || pop);
    pop_ok = rd_en || bypass;
  end

  // Storage array, written without reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= din;
  end

  // Pointers, occupancy and registered read data.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      dout  <= '0;
    end else begin
      if (wr_en) wptr <= wptr + AW'(1);
      if (rd_en) begin
        rptr <= rptr + AW'(1);
        dout <= mem[rptr];
      end else if (bypass) begin
        dout <= din;
      end
      case ({wr_en, rd_en})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/dsp_sample_ctrl.sv
// Sample controller between decimator/interpolator and CPU FIFOs.
// Build option: define DSP_SAMPLE_CTRL_STATS_EN to get saturating overflow
// and underrun counters; otherwise ovf_cnt/udf_cnt are tied to zero.
module dsp_sample_ctrl
  import dsp_sample_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int RATE  = 32
) (
  input  logic                       sys_clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic signed [SAMPLE_W-1:0] down_data,
  input  logic                       down_valid,
  input  logic                       rd_req,
  output logic signed [SAMPLE_W-1:0] rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH):0]     rx_level,
  input  logic                       wr_req,
  input  logic signed [SAMPLE_W-1:0] wr_data,
  output logic [$clog2(DEPTH):0]     tx_level,
  output logic signed [SAMPLE_W-1:0] up_data,
  output logic                       up_tick,
  output logic [1:0]                 state,
  output logic [CNT_W-1:0]           ovf_cnt,
  output logic [CNT_W-1:0]           udf_cnt
);

  localparam int CW = $clog2(RATE);

  state_t        cur_state;
  state_t        next_state;
  logic [CW-1:0] rate_cnt;
  logic          active;
  logic          fire;
  logic          rx_push;
  logic          rx_pop;
  logic          tx_push;
  logic          tx_pop;
  logic          rx_full;
  logic          rx_empty;
  logic          rx_pop_ok;
  logic          tx_full;
  logic          tx_empty;
  logic          tx_pop_ok;
  logic          unused_tx;

  // Next-state and datapath control. Everything is gated by enable so the
  // edge that leaves for IDLE already clears the FIFOs and suppresses ticks.
  always_comb begin
    next_state = cur_state;
    case (cur_state)
      IDLE:    next_state = ALIGN;
      ALIGN:   if (down_valid) next_state = RUN;
      RUN:     next_state = RUN;
      default: next_state = IDLE;
    endcase
    if (!enable) next_state = IDLE;
    active  = enable && (cur_state != IDLE);
    fire    = enable && (cur_state == RUN) && (rate_cnt == CW'(RATE - 1));
    rx_push = active && down_valid;
    rx_pop  = active && rd_req;
    tx_push = active && wr_req;
    tx_pop  = fire && !tx_empty;
  end

  // State register.
  always_ff @(posedge sys_clk) begin
    if (reset) cur_state <= IDLE;
    else       cur_state <= next_state;
  end

  // Rate counter: held at zero outside RUN, so the ALIGN->RUN edge loads 0.
  always_ff @(posedge sys_clk) begin
    if (reset || fire || !enable || cur_state != RUN) rate_cnt <= '0;
    else                                              rate_cnt <= rate_cnt + CW'(1);
  end

  // Registered strobes.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      rd_valid <= 1'b0;
      up_tick  <= 1'b0;
    end else begin
      rd_valid <= rx_pop_ok;
      up_tick  <= fire;
    end
  end

  sample_fifo #(.DEPTH(DEPTH), .W(SAMPLE_W)) u_rx (
    .clk    (sys_clk),
    .reset  (reset),
    .clear  (!active),
    .push   (rx_push),
    .din    (down_data),
    .pop    (rx_pop),
    .dout   (rd_data),
    .full   (rx_full),
    .empty  (rx_empty),
    .level  (rx_level),
    .pop_ok (rx_pop_ok)
  );

  sample_fifo #(.DEPTH(DEPTH), .W(SAMPLE_W)) u_tx (
    .clk    (sys_clk),
    .reset  (reset),
    .clear  (!active),
    .push   (tx_push),
    .din    (wr_data),
    .pop    (tx_pop),
    .dout   (up_data),
    .full   (tx_full),
    .empty  (tx_empty),
    .level  (tx_level),
    .pop_ok (tx_pop_ok)
  );

  assign state     = cur_state;
  assign unused_tx = tx_full ^ tx_pop_ok ^ rx_empty;

`ifdef DSP_SAMPLE_CTRL_STATS_EN
  logic ovf_evt;
  logic udf_evt;

  assign ovf_evt = rx_push && rx_full && !rx_pop;
  assign udf_evt = fire && tx_empty;

  // Saturating event counters, cleared only by reset.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      ovf_cnt <= '0;
      udf_cnt <= '0;
    end else begin
      if (ovf_evt && ovf_cnt != '1) ovf_cnt <= ovf_cnt + CNT_W'(1);
      if (udf_evt && udf_cnt != '1) udf_cnt <= udf_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_stats;

  assign unused_stats = rx_full;
  assign ovf_cnt      = '0;
  assign udf_cnt      = '0;
`endif

endmodule

// File: tb/tb_dsp_sample_ctrl.sv
// Directed bench for dsp_sample_ctrl with rx/tx scoreboards.
module tb_dsp_sample_ctrl;
  import dsp_sample_pkg::*;

  localparam int DEPTH = 8;
  localparam int RATE  = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic          reset, enable, down_valid, rd_req, wr_req, rd_valid, up_tick;
  logic [15:0]   down_data, wr_data, rd_data, up_data, ovf_cnt, udf_cnt;
  logic [LW-1:0] rx_level, tx_level;
  logic [1:0]    state;

  dsp_sample_ctrl #(.DEPTH(DEPTH), .RATE(RATE)) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .enable     (enable),
    .down_data  (down_data),
    .down_valid (down_valid),
    .rd_req     (rd_req),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rx_level   (rx_level),
    .wr_req     (wr_req),
    .wr_data    (wr_data),
    .tx_level   (tx_level),
    .up_data    (up_data),
    .up_tick    (up_tick),
    .state      (state),
    .ovf_cnt    (ovf_cnt),
    .udf_cnt    (udf_cnt)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] rx_q[$];
  logic [15:0] tx_q[$];
  logic [15:0] exp_up;
  int          exp_ovf, exp_udf, cyc, last_tick, rd_cnt, t_cnt;
  bit          exp_run;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] stat(input int v);
`ifdef DSP_SAMPLE_CTRL_STATS_EN
    return (v > 65535) ? 32'd65535 : v;
`else
    return (v > 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  // One clock: sample #1 after the edge, score rd/up strobes, then record
  // the tx push of that edge (a push never feeds the tick of the same edge).
  task automatic step();
    logic        w, rs;
    logic [15:0] wd;
    w  = wr_req;
    wd = wr_data;
    rs = reset;
    @(posedge sys_clk);
    #1;
    cyc++;
    if (rd_valid) begin
      rd_cnt++;
      chk("rd_expected", rx_q.size() != 0, 1);
      if (rx_q.size() != 0) chk("rd_data", rd_data, rx_q.pop_front());
    end
    if (up_tick) begin
      chk("tick_in_run", exp_run, 1);
      if (last_tick >= 0) chk("tick_period", cyc - last_tick, RATE);
      last_tick = cyc;
      if (tx_q.size() != 0) exp_up = tx_q.pop_front();
      else exp_udf++;
      chk("up_data", up_data, exp_up);
    end
    if (w && !rs && tx_q.size() < DEPTH) tx_q.push_back(wd);
  endtask

  task automatic wait_tick(input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!up_tick && n < 2 * RATE);
    chk(tag, up_tick, 1);
  endtask

  initial begin
    reset = 1; enable = 0; down_valid = 0; down_data = 0;
    rd_req = 0; wr_req = 0; wr_data = 0;
    exp_up = 0; exp_ovf = 0; exp_udf = 0; exp_run = 0;
    cyc = 0; last_tick = -1; rd_cnt = 0;

    step(); step();
    chk("rst_state", state, IDLE);
    chk("rst_rx_level", rx_level, 0);
    chk("rst_tx_level", tx_level, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_up_tick", up_tick, 0);
    chk("rst_up_data", up_data, 0);
    chk("rst_ovf", ovf_cnt, stat(0));
    reset = 0;

    // Alignment: down_valid first presented at the 10th enabled edge.
    enable = 1;
    for (int i = 1; i <= 9; i++) begin
      step();
      chk("state_align", state, ALIGN);
    end
    down_valid = 1; down_data = 16'h0001; rx_q.push_back(16'h0001);
    step();
    down_valid = 0;
    chk("state_run", state, RUN);
    exp_run = 1; last_tick = -1;
    t_cnt = 0;
    repeat (RATE - 1) begin
      step();
      if (up_tick) t_cnt++;
    end
    chk("no_early_tick", t_cnt, 0);
    step();
    chk("first_tick", up_tick, 1);

    // Rx overflow: samples 2..10 after the captured sample 1.
    for (int i = 2; i <= 10; i++) begin
      down_valid = 1; down_data = 16'(i);
      if (i <= DEPTH) rx_q.push_back(16'(i));
      else exp_ovf++;
      step();
    end
    down_valid = 0;
    chk("rx_full_level", rx_level, DEPTH);
    chk("ovf_cnt", ovf_cnt, stat(exp_ovf));
    repeat (DEPTH) begin
      rd_req = 1; step(); rd_req = 0; step();
    end
    chk("rx_drained", rx_level, 0);
    chk("rd_count", rd_cnt, DEPTH);

    // Pop on empty does nothing.
    rd_req = 1; step(); rd_req = 0;
    chk("empty_pop", rd_valid, 0);

    // Push and pop together on an empty FIFO.
    down_valid = 1; down_data = 16'h0055; rd_req = 1; rx_q.push_back(16'h0055);
    step();
    down_valid = 0; rd_req = 0;
    chk("bypass_valid", rd_valid, 1);
    chk("bypass_level", rx_level, 0);

    // Push and pop together on a full FIFO.
    for (int i = 0; i < DEPTH; i++) begin
      down_valid = 1; down_data = 16'(16'h0100 + i); rx_q.push_back(16'(16'h0100 + i));
      step();
    end
    down_valid = 1; down_data = 16'h0200; rd_req = 1; rx_q.push_back(16'h0200);
    step();
    down_valid = 0; rd_req = 0;
    chk("full_pp_valid", rd_valid, 1);
    chk("full_pp_level", rx_level, DEPTH);
    chk("full_pp_ovf", ovf_cnt, stat(exp_ovf));
    repeat (DEPTH) begin
      rd_req = 1; step(); rd_req = 0; step();
    end
    chk("rx_drained2", rx_level, 0);

    // Underrun holds the last sample.
    wr_req = 1; wr_data = 16'h1234; step(); wr_req = 0;
    wait_tick("tick_1234");
    repeat (3) wait_tick("tick_udf");
    chk("hold_1234", up_data, 16'h1234);
    chk("udf_cnt", udf_cnt, stat(exp_udf));

    // Extreme signed values through the tx path.
    wr_req = 1; wr_data = 16'h7FFF; step();
    wr_data = 16'h8000; step(); wr_req = 0;
    wait_tick("tick_a");
    wait_tick("tick_b");
    chk("tx_empty_level", tx_level, 0);
    chk("up_8000", up_data, 16'h8000);

    // Dropping enable with five samples queued.
    for (int i = 0; i < 5; i++) begin
      down_valid = 1; down_data = 16'(16'h0300 + i); rx_q.push_back(16'(16'h0300 + i));
      step();
    end
    down_valid = 0;
    chk("rx_level5", rx_level, 5);
    exp_run = 0; enable = 0;
    step();
    rx_q.delete(); tx_q.delete(); exp_up = 0; last_tick = -1;
    rd_req = 1;
    step();
    chk("idle_state", state, IDLE);
    chk("idle_rx_level", rx_level, 0);
    chk("idle_up_data", up_data, 0);
    repeat (3) step();
    chk("idle_rd_ignored", rd_valid, 0);
    rd_req = 0;

    // Reset in RUN with both FIFOs loaded and a read in flight.
    enable = 1; step();
    down_valid = 1; down_data = 16'h0400; rx_q.push_back(16'h0400);
    step();
    exp_run = 1;
    for (int i = 1; i <= DEPTH; i++) begin
      down_valid = 1; down_data = 16'(16'h0400 + i);
      wr_req = 1; wr_data = 16'(16'h0500 + i);
      if (i < DEPTH) rx_q.push_back(16'(16'h0400 + i));
      else exp_ovf++;
      step();
    end
    down_valid = 0; wr_req = 0;
    chk("pre_rst_rx_level", rx_level, DEPTH);
    chk("pre_rst_ovf", ovf_cnt, stat(exp_ovf));
    rd_req = 1; step();
    reset = 1; enable = 0;
    step();
    chk("mid_state", state, IDLE);
    chk("mid_rx_level", rx_level, 0);
    chk("mid_tx_level", tx_level, 0);
    chk("mid_rd_data", rd_data, 0);
    chk("mid_rd_valid", rd_valid, 0);
    chk("mid_up_data", up_data, 0);
    chk("mid_up_tick", up_tick, 0);
    chk("mid_ovf", ovf_cnt, 0);
    chk("mid_udf", udf_cnt, 0);
    reset = 0; rd_req = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
